// File: rtl/rv32i_run_pkg.sv
// rv32i_run_pkg: shared state/status encodings and default constants for the run controller
package rv32i_run_pkg;
    typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;
    typedef enum logic [1:0] {NONE, HALT, TOHOST, TIMEOUT} status_t;
    localparam logic [31:0] DEF_HALT_INSTR  = 32'h0000_006F;
    localparam logic [31:0] DEF_TOHOST_ADDR = 32'h0000_00FC;
endpackage

// File: rtl/run_halt_detect.sv
// run_halt_detect: flags a core spinning on the halt instruction at an unchanged PC
module run_halt_detect import rv32i_run_pkg::*; #(
    parameter logic [31:0] HALT_INSTR  = DEF_HALT_INSTR,
    parameter int          HALT_REPEAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output logic        halt_hit
);
    localparam int SW = $clog2(HALT_REPEAT + 1);

    logic [31:0]   prev_pc;
    logic          prev_valid;
    logic [SW-1:0] streak;
    logic          match;

    // prev_valid drops outside RUN so the first RUN cycle never compares against a stale PC
    assign match    = en && prev_valid && instr == HALT_INSTR && pc == prev_pc;
    assign halt_hit = match && streak == SW'(HALT_REPEAT - 1);

    // track previous PC and the length of the current halt streak
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_pc    <= '0;
            prev_valid <= 1'b0;
            streak     <= '0;
        end else begin
            prev_pc    <= pc;
            prev_valid <= en;
            streak     <= match ? streak + 1'b1 : '0;
        end
    end
endmodule

// File: rtl/rv32i_run_ctrl.sv
// rv32i_run_ctrl: sequences core reset, runs the core and detects halt, tohost store or timeout
module rv32i_run_ctrl import rv32i_run_pkg::*; #(
    parameter int          RST_HOLD_CYCLES = 2,
    parameter int          MAX_CYCLES      = 60,
    parameter int          CNT_W           = 16,
    parameter logic [31:0] HALT_INSTR      = DEF_HALT_INSTR,
    parameter int          HALT_REPEAT     = 2,
    parameter logic [31:0] TOHOST_ADDR     = DEF_TOHOST_ADDR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      instr_i,
    input  logic             dmem_we_i,
    input  logic [31:0]      dmem_addr_i,
    input  logic [31:0]      dmem_wdata_i,
    output logic             cpu_rst_o,
    output logic             running_o,
    output logic             done_o,
    output logic [1:0]       status_o,
    output logic [31:0]      result_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);
    localparam int               HW        = $clog2(RST_HOLD_CYCLES + 1);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_CYCLES == 0 ? 0 : MAX_CYCLES - 1);

    state_t        state, next;
    status_t       cause;
    logic          launch, halt_hit, tohost_hit, timeout_hit;
    logic [HW-1:0] hold_cnt;

    assign tohost_hit  = dmem_we_i && dmem_addr_i == TOHOST_ADDR;
    assign timeout_hit = MAX_CYCLES != 0 && cycle_cnt_o == CNT_LAST;

    run_halt_detect #(
        .HALT_INSTR  (HALT_INSTR),
        .HALT_REPEAT (HALT_REPEAT)
    ) u_halt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state == RUN),
        .pc       (pc_i),
        .instr    (instr_i),
        .halt_hit (halt_hit)
    );

    // next state and end-cause selection; abort overrides everything, including start
    always_comb begin
        next   = state;
        launch = 1'b0;
        cause  = tohost_hit ? TOHOST : halt_hit ? HALT : timeout_hit ? TIMEOUT : NONE;
        case (state)
            IDLE, DONE: begin
                launch = start_i;
                next   = start_i ? HOLD : state;
            end
            HOLD: next = hold_cnt == HOLD_LAST ? RUN : HOLD;
            RUN:  next = cause != NONE ? DONE : RUN;
        endcase
        if (abort_i) begin
            next   = IDLE;
            launch = 1'b0;
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    // registered outputs, hold counter, run counter and end-of-run capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rst_o   <= 1'b1;
            running_o   <= 1'b0;
            done_o      <= 1'b0;
            status_o    <= NONE;
            result_o    <= '0;
            cycle_cnt_o <= '0;
            hold_cnt    <= '0;
        end else begin
            cpu_rst_o <= next != RUN;
            running_o <= next == RUN;
            done_o    <= next == DONE;
            hold_cnt  <= state == HOLD && next == HOLD ? hold_cnt + 1'b1 : '0;
            if (abort_i) begin
                status_o <= NONE;
                result_o <= '0;
            end else if (launch) begin
                status_o    <= NONE;
                result_o    <= '0;
                cycle_cnt_o <= '0;
            end else if (state == RUN) begin
                cycle_cnt_o <= &cycle_cnt_o ? cycle_cnt_o : cycle_cnt_o + 1'b1;
                status_o    <= cause;
                if (cause == TOHOST) result_o <= dmem_wdata_i;
            end
        end
    end
endmodule

// File: tb/tb_rv32i_run_ctrl.sv
// tb_rv32i_run_ctrl: scoreboard bench with directed runs covering every end cause and control path
module tb_rv32i_run_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_i = 1'b0, abort_i = 1'b0, start0 = 1'b0;
    logic [31:0] pc_i = '0, instr_i = 32'h13, dmem_addr_i = '0, dmem_wdata_i = '0;
    logic        dmem_we_i = 1'b0;
    logic        cpu_rst_o, running_o, done_o;
    logic [1:0]  status_o;
    logic [31:0] result_o;
    logic [15:0] cycle_cnt_o;
    logic        cpu_rst0, running0, done0;
    logic [1:0]  status0;
    logic [31:0] result0;
    logic [15:0] cnt0;
    logic        seq = 1'b0;
    logic        done_q = 1'b0;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] res;
        logic [15:0] cnt;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    rv32i_run_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .pc_i(pc_i), .instr_i(instr_i), .dmem_we_i(dmem_we_i),
        .dmem_addr_i(dmem_addr_i), .dmem_wdata_i(dmem_wdata_i),
        .cpu_rst_o(cpu_rst_o), .running_o(running_o), .done_o(done_o),
        .status_o(status_o), .result_o(result_o), .cycle_cnt_o(cycle_cnt_o)
    );

    rv32i_run_ctrl #(.MAX_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start0), .abort_i(1'b0),
        .pc_i(32'h0), .instr_i(32'h13), .dmem_we_i(1'b0),
        .dmem_addr_i(32'h0), .dmem_wdata_i(32'h0),
        .cpu_rst_o(cpu_rst0), .running_o(running0), .done_o(done0),
        .status_o(status0), .result_o(result0), .cycle_cnt_o(cnt0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (seq) pc_i = pc_i + 32'd4;
    endtask

    task automatic push(input logic [1:0] st, input logic [31:0] res, input logic [15:0] cnt);
        exp_t e;
        e.st = st; e.res = res; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d end-of-run results still pending", sb.size());
            sb.delete();
        end
    endtask

    task automatic launch();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("hold1_cpu_rst", cpu_rst_o, 1);
        chk("hold1_running", running_o, 0);
        chk("hold1_done", done_o, 0);
        tick();
        chk("hold2_cpu_rst", cpu_rst_o, 1);
        chk("hold2_running", running_o, 0);
        tick();
        chk("run_cpu_rst", cpu_rst_o, 0);
        chk("run_running", running_o, 1);
        chk("run_cnt0", cycle_cnt_o, 0);
    endtask

    task automatic halt_cycles(input logic [31:0] pc, input logic tohost, input logic [31:0] data);
        seq = 1'b0;
        pc_i = pc;
        instr_i = 32'h6F;
        for (int k = 0; k < 3; k++) begin
            dmem_we_i = tohost && k == 2;
            dmem_addr_i = 32'hFC;
            dmem_wdata_i = data;
            tick();
        end
        dmem_we_i = 1'b0;
        instr_i = 32'h13;
        seq = 1'b1;
    endtask

    // end-of-run monitor: each rising done_o consumes one expected result
    always @(negedge clk) begin
        if (!rst_n) done_q = 1'b0;
        else begin
            if (done_o && !done_q) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: status %0d cnt %0d with nothing expected", status_o, cycle_cnt_o);
                end else begin
                    mon_e = sb.pop_front();
                    chk("end_status", 32'(status_o), 32'(mon_e.st));
                    chk("end_result", result_o, mon_e.res);
                    chk("end_cnt", 32'(cycle_cnt_o), 32'(mon_e.cnt));
                end
            end
            done_q = done_o;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_cpu_rst", cpu_rst_o, 1);
        chk("rst_running", running_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_status", 32'(status_o), 0);
        chk("rst_result", result_o, 0);
        chk("rst_cnt", 32'(cycle_cnt_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_cpu_rst", cpu_rst_o, 1);

        // MAX_CYCLES=0 instance: no timeout within 200 run cycles
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        tick();
        chk("nto_running", running0, 1);
        repeat (200) tick();
        chk("nto_done", done0, 0);
        chk("nto_still_running", running0, 1);
        chk("nto_cnt", 32'(cnt0), 200);

        // launch, count 1..3, then halt loop at 0x40
        seq = 1'b1;
        launch();
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("cnt_step", 32'(cycle_cnt_o), k);
        end
        push(2'd1, 32'h0, 16'd6);
        halt_cycles(32'h40, 1'b0, 32'h0);
        chk("halt_cpu_rst", cpu_rst_o, 1);
        chk("halt_running", running_o, 0);
        chk("halt_done", done_o, 1);
        drain();

        // restart after DONE: store to 0xF8 ignored, tohost store at cycle 20
        launch();
        push(2'd2, 32'h1, 16'd20);
        for (int k = 1; k <= 20; k++) begin
            dmem_we_i = k == 10 || k == 20;
            dmem_addr_i = k == 10 ? 32'hF8 : 32'hFC;
            dmem_wdata_i = k == 10 ? 32'hDEAD : 32'h1;
            tick();
            if (k == 10) chk("f8_no_end", running_o, 1);
        end
        dmem_we_i = 1'b0;
        drain();

        // timeout after exactly 60 cycles; start during RUN ignored
        launch();
        for (int k = 1; k <= 59; k++) begin
            start_i = k == 30;
            tick();
            if (k == 30) chk("start_in_run_cnt", 32'(cycle_cnt_o), 30);
        end
        start_i = 1'b0;
        chk("pre_timeout_done", done_o, 0);
        push(2'd3, 32'h0, 16'd60);
        tick();
        drain();

        // tohost, halt and timeout all in cycle 60: tohost wins
        launch();
        repeat (57) tick();
        push(2'd2, 32'h55, 16'd60);
        halt_cycles(32'h80, 1'b1, 32'h55);
        drain();

        // halt and timeout in cycle 60: halt wins
        launch();
        repeat (57) tick();
        push(2'd1, 32'h0, 16'd60);
        halt_cycles(32'h80, 1'b0, 32'h0);
        drain();

        // abort and start together in DONE: abort wins
        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("abort_done", done_o, 0);
        chk("abort_status", 32'(status_o), 0);
        chk("abort_cpu_rst", cpu_rst_o, 1);
        chk("abort_cnt_hold", 32'(cycle_cnt_o), 60);
        repeat (3) tick();
        chk("abort_stay_idle", running_o, 0);

        // abort mid-run
        launch();
        repeat (5) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("run_abort_running", running_o, 0);
        chk("run_abort_cpu_rst", cpu_rst_o, 1);
        chk("run_abort_cnt", 32'(cycle_cnt_o), 5);

        // async reset at run cycle 10, then rerun with cleared counters
        launch();
        repeat (10) tick();
        chk("pre_rst_cnt", 32'(cycle_cnt_o), 10);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cpu_rst", cpu_rst_o, 1);
        chk("arst_running", running_o, 0);
        chk("arst_cnt", 32'(cycle_cnt_o), 0);
        chk("arst_status", 32'(status_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        launch();
        push(2'd2, 32'hABCD, 16'd3);
        for (int k = 1; k <= 3; k++) begin
            dmem_we_i = k == 3;
            dmem_addr_i = 32'hFC;
            dmem_wdata_i = 32'hABCD;
            tick();
        end
        dmem_we_i = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rv32i_run_ctrl.md
Name: rv32i_run_ctrl

Overview:
- Synthesizable run controller for the RV32I_TOP core. It sequences core reset, then lets the core run, and decides when a program has finished.
- Three end conditions: self-loop halt (e.g. `jal x0,0`), a store to a tohost-style address, or a cycle-budget timeout.
- Sits between board/bench stimulus and the core. It replaces the fixed "release reset, wait N clocks, stop" procedure with parametrised, observable hardware status.

Parameters:
- RST_HOLD_CYCLES, 2, number of cycles cpu_rst_o is held high after start (≥1).
- MAX_CYCLES, 60, run-cycle budget before timeout; 0 disables timeout.
- CNT_W, 16, width of the cycle counter (≥ clog2(MAX_CYCLES+1)).
- HALT_INSTR, 32'h0000_006F, instruction word treated as halt (`jal x0,0`).
- HALT_REPEAT, 2, consecutive RUN cycles HALT_INSTR must be seen at an unchanged PC (≥1).
- TOHOST_ADDR, 32'h0000_00FC, data-memory word address whose store ends the run.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  launch a run; accepted in IDLE or DONE only.
- abort_i  in  1  cancel the run; return to IDLE.
- pc_i  in  32  core fetch PC.
- instr_i  in  32  instruction word fetched at pc_i.
- dmem_we_i  in  1  core data-memory write enable.
- dmem_addr_i  in  32  core data-memory address.
- dmem_wdata_i  in  32  core data-memory write data.
- cpu_rst_o  out  1  active-high reset to RV32I_TOP.
- running_o  out  1  high in RUN.
- done_o  out  1  sticky end-of-run flag.
- status_o  out  2  end cause: 0 NONE, 1 HALT, 2 TOHOST, 3 TIMEOUT.
- result_o  out  32  dmem_wdata_i captured on the tohost store; otherwise 0.
- cycle_cnt_o  out  CNT_W  RUN cycles elapsed.

Behaviour:
- Reset (rst_n=0, async): state IDLE, cpu_rst_o=1, running_o=0, done_o=0, status_o=0, result_o=0, cycle_cnt_o=0, hold counter=0, halt streak=0.
- All outputs are registered. State encoding is IDLE, HOLD, RUN, DONE.
- IDLE: cpu_rst_o=1.
  - start_i → HOLD. On that edge clear done_o, status_o, result_o and cycle_cnt_o.
- HOLD: cpu_rst_o=1 for exactly RST_HOLD_CYCLES cycles, counted from the first cycle in HOLD.
  - Then → RUN. cpu_rst_o falls on the same edge at which running_o rises.
- RUN: cpu_rst_o=0, running_o=1. cycle_cnt_o increments on every RUN cycle and saturates at all-ones.
- Tohost condition: dmem_we_i=1 and dmem_addr_i==TOHOST_ADDR. On that edge capture result_o=dmem_wdata_i, set status=2, → DONE.
- Halt condition: instr_i==HALT_INSTR and pc_i equals the previous cycle's pc_i.
  - The streak counter increments while the condition holds and clears otherwise.
  - When the streak reaches HALT_REPEAT: status=1, → DONE.
  - The first RUN cycle has no valid previous PC, so its streak is 0.
- Timeout: MAX_CYCLES≠0 and the counter value before increment equals MAX_CYCLES-1. The run therefore lasts exactly MAX_CYCLES cycles. Set status=3, → DONE.
- Simultaneous end causes in one cycle: priority TOHOST > HALT > TIMEOUT. The cycle counter still counts the final cycle.
- DONE: cpu_rst_o=1 (core frozen), running_o=0, done_o=1. status_o, result_o and cycle_cnt_o hold.
  - start_i → HOLD (restart).
- abort_i in HOLD, RUN or DONE → IDLE next edge, with cpu_rst_o=1, running_o=0, done_o=0, status_o=0. cycle_cnt_o holds.
  - abort_i beats start_i when both are asserted.
- start_i during HOLD or RUN is ignored.
- rst_n asserted mid-run forces the reset values immediately, asynchronously.

Decomposition:
- Package rv32i_run_pkg holds:
  - state enum: IDLE, HOLD, RUN, DONE;
  - status enum: NONE, HALT, TOHOST, TIMEOUT;
  - default constants: HALT_INSTR, TOHOST_ADDR.
- One natural sub-module, run_halt_detect. It owns the prev-PC register and the streak counter, and outputs halt_hit.
- FSM, counters and capture registers stay in the top module.

Test Plan:
- Reset/launch: rst_n low 3 cycles, then start_i pulse → cpu_rst_o=1 for 2 HOLD cycles, then running_o=1; cycle_cnt_o goes 1,2,3 on successive edges.
- Halt: core fetches 0x0000006F at pc 0x40 repeatedly → done_o=1, status_o=1 after 2 matching cycles (the first RUN match does not count); cpu_rst_o returns to 1.
- Tohost: store 0x0000_0001 to 0xFC at run cycle 20 → status_o=2, result_o=1, cycle_cnt_o=20. A store to 0xF8 does not end the run.
- Timeout: program with no halt, MAX_CYCLES=60 → done_o after exactly 60 RUN cycles, status_o=3, cycle_cnt_o=60. With MAX_CYCLES=0 no timeout occurs in 200 cycles.
- Priority/collision: tohost store and final timeout cycle coincide → status_o=2. abort_i and start_i together in DONE → IDLE, done_o=0.
- Mid-run reset/restart: rst_n low at run cycle 10 → all outputs at reset values asynchronously. A later start_i after DONE reruns with counters cleared.
